cpu_controller: RTL and testbench

//  Instruction register plus control FSM that sequences the 16-bit datapath (regfile, A/B latches, shifter, ALU, writeback mux).

---
 rtl/cpu_ctrl_pkg.sv | 74 +++++++
 rtl/cpu_controller_instr_decoder.sv | 27 ++
 rtl/cpu_controller.sv | 169 ++++++++++++++++
 tb/tb_cpu_controller.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_ctrl_pkg.sv
// Shared types and encodings for the CPU controller: FSM states, ISA field codes,
// ALU / writeback select codes and the registered control-word bundle.
package cpu_ctrl_pkg;

  typedef enum logic [2:0] {
    S_WAIT,
    S_DECODE,
    S_WR_IMM,
    S_GET_A,
    S_GET_B,
    S_CALC,
    S_WR_REG,
    S_HALT
  } state_t;

  typedef enum logic [2:0] {
    K_MOV_IMM,
    K_MOV_REG,
    K_ADD,
    K_CMP,
    K_AND,
    K_MVN,
    K_UNDEF
  } kind_t;

  localparam logic [2:0] OPC_MOV = 3'b110;
  localparam logic [2:0] OPC_ALU = 3'b101;

  localparam logic [1:0] OP_MOV_REG = 2'b00;
  localparam logic [1:0] OP_MOV_IMM = 2'b10;
  localparam logic [1:0] OP_ADD     = 2'b00;
  localparam logic [1:0] OP_CMP     = 2'b01;
  localparam logic [1:0] OP_AND     = 2'b10;
  localparam logic [1:0] OP_MVN     = 2'b11;

  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_SUB = 2'b01;
  localparam logic [1:0] ALU_AND = 2'b10;
  localparam logic [1:0] ALU_MVN = 2'b11;

  localparam logic [1:0] WB_ALU = 2'b00;
  localparam logic [1:0] WB_PC  = 2'b01;
  localparam logic [1:0] WB_IMM = 2'b10;
  localparam logic [1:0] WB_MEM = 2'b11;

  typedef struct packed {
    logic       w;
    logic [2:0] r_addr;
    logic [2:0] w_addr;
    logic       w_en;
    logic       en_a;
    logic       en_b;
    logic [1:0] shift_op;
    logic       sel_a;
    logic       sel_b;
    logic [1:0] alu_op;
    logic       en_c;
    logic       en_status;
    logic [1:0] wb_sel;
  } ctrl_t;

  function automatic kind_t decode_kind(input logic [2:0] opcode, input logic [1:0] op);
    case ({opcode, op})
      {OPC_MOV, OP_MOV_IMM}: return K_MOV_IMM;
      {OPC_MOV, OP_MOV_REG}: return K_MOV_REG;
      {OPC_ALU, OP_ADD}:     return K_ADD;
      {OPC_ALU, OP_CMP}:     return K_CMP;
      {OPC_ALU, OP_AND}:     return K_AND;
      {OPC_ALU, OP_MVN}:     return K_MVN;
      default:               return K_UNDEF;
    endcase
  endfunction

endpackage

// File: rtl/cpu_controller_instr_decoder.sv
// Combinational instruction field split plus the two sign-extended immediates.
// Field positions are fixed for a 16-bit instruction word.
module instr_decoder #(
  parameter int DATA_W = 16
) (
  input  logic [DATA_W-1:0] ir,
  output logic [2:0]        opcode,
  output logic [1:0]        op,
  output logic [2:0]        rn,
  output logic [2:0]        rd,
  output logic [1:0]        sh,
  output logic [2:0]        rm,
  output logic [DATA_W-1:0] sximm8,
  output logic [DATA_W-1:0] sximm5
);

  assign opcode = ir[15:13];
  assign op     = ir[12:11];
  assign rn     = ir[10:8];
  assign rd     = ir[7:5];
  assign sh     = ir[4:3];
  assign rm     = ir[2:0];

  assign sximm8 = {{(DATA_W-8){ir[7]}}, ir[7:0]};
  assign sximm5 = {{(DATA_W-5){ir[4]}}, ir[4:0]};

endmodule

// File: rtl/cpu_controller.sv
// Instruction register and control FSM for the 16-bit datapath; all outputs registered.
// Optional feature: CPU_CTRL_ILLEGAL_TRAP_EN traps undefined encodings into HALT.
module cpu_controller
  import cpu_ctrl_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int REG_AW = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] in,
  input  logic              load,
  input  logic              s,
  output logic              w,
  output logic [REG_AW-1:0] r_addr,
  output logic [REG_AW-1:0] w_addr,
  output logic              w_en,
  output logic              en_A,
  output logic              en_B,
  output logic [1:0]        shift_op,
  output logic              sel_A,
  output logic              sel_B,
  output logic [1:0]        ALU_op,
  output logic              en_C,
  output logic              en_status,
  output logic [1:0]        wb_sel,
  output logic [DATA_W-1:0] sximm8,
  output logic [DATA_W-1:0] sximm5,
  output logic              illegal
);

  state_t            state_reg, state_next;
  logic [DATA_W-1:0] ir_reg, ir_next;
  logic              illegal_reg, illegal_next;
  ctrl_t             ctrl_reg, ctrl_next;
  logic [DATA_W-1:0] sximm8_reg, sximm5_reg;

  logic [2:0]        dec_opcode, dec_rn, dec_rd, dec_rm;
  logic [1:0]        dec_op, dec_sh;
  logic [DATA_W-1:0] dec_sximm8, dec_sximm5;
  kind_t             kind;

  // Decoding the next IR lets every output be registered yet line up with its state.
  instr_decoder #(.DATA_W(DATA_W)) u_decoder (
    .ir     (ir_next),
    .opcode (dec_opcode),
    .op     (dec_op),
    .rn     (dec_rn),
    .rd     (dec_rd),
    .sh     (dec_sh),
    .rm     (dec_rm),
    .sximm8 (dec_sximm8),
    .sximm5 (dec_sximm5)
  );

  assign kind = decode_kind(dec_opcode, dec_op);

  always_comb begin
    ir_next = ir_reg;
    if (state_reg == S_WAIT && load) begin
      ir_next = in;
    end
  end

  always_comb begin
    state_next   = state_reg;
    illegal_next = illegal_reg;
    case (state_reg)
      S_WAIT:   if (s) state_next = S_DECODE;
      S_DECODE: begin
        case (kind)
          K_MOV_IMM:           state_next = S_WR_IMM;
          K_MOV_REG, K_MVN:    state_next = S_GET_B;
          K_ADD, K_CMP, K_AND: state_next = S_GET_A;
          default: begin
`ifdef CPU_CTRL_ILLEGAL_TRAP_EN
            state_next   = S_HALT;
            illegal_next = 1'b1;
`else
            state_next   = S_WAIT;
`endif
          end
        endcase
      end
      S_WR_IMM: state_next = S_WAIT;
      S_GET_A:  state_next = S_GET_B;
      S_GET_B:  state_next = S_CALC;
      S_CALC:   state_next = (kind == K_CMP) ? S_WAIT : S_WR_REG;
      S_WR_REG: state_next = S_WAIT;
      S_HALT:   state_next = S_HALT;
      default:  state_next = S_WAIT;
    endcase
`ifndef CPU_CTRL_ILLEGAL_TRAP_EN
    illegal_next = 1'b0;
`endif
  end

  always_comb begin
    ctrl_next = '0;
    case (state_next)
      S_WAIT: ctrl_next.w = 1'b1;
      S_WR_IMM: begin
        ctrl_next.w_en   = 1'b1;
        ctrl_next.w_addr = dec_rn;
        ctrl_next.wb_sel = WB_IMM;
      end
      S_GET_A: begin
        ctrl_next.r_addr = dec_rn;
        ctrl_next.en_a   = 1'b1;
      end
      S_GET_B: begin
        ctrl_next.r_addr = dec_rm;
        ctrl_next.en_b   = 1'b1;
      end
      S_CALC, S_WR_REG: begin
        ctrl_next.en_c     = 1'b1;
        ctrl_next.shift_op = dec_sh;
        // MOV reg passes B through as 0 + B; the ALU-class op field already equals the ALU code.
        ctrl_next.sel_a    = (kind == K_MOV_REG);
        ctrl_next.alu_op   = (kind == K_MOV_REG) ? ALU_ADD : dec_op;
        if (state_next == S_CALC) begin
          ctrl_next.en_status = (kind == K_CMP);
        end else begin
          ctrl_next.w_en   = 1'b1;
          ctrl_next.w_addr = dec_rd;
          ctrl_next.wb_sel = WB_ALU;
        end
      end
      default: ctrl_next = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg   <= S_WAIT;
      ir_reg      <= '0;
      illegal_reg <= 1'b0;
      ctrl_reg    <= '0;
      ctrl_reg.w  <= 1'b1;
      sximm8_reg  <= '0;
      sximm5_reg  <= '0;
    end else begin
      state_reg   <= state_next;
      ir_reg      <= ir_next;
      illegal_reg <= illegal_next;
      ctrl_reg    <= ctrl_next;
      sximm8_reg  <= dec_sximm8;
      sximm5_reg  <= dec_sximm5;
    end
  end

  assign w         = ctrl_reg.w;
  assign r_addr    = ctrl_reg.r_addr;
  assign w_addr    = ctrl_reg.w_addr;
  assign w_en      = ctrl_reg.w_en;
  assign en_A      = ctrl_reg.en_a;
  assign en_B      = ctrl_reg.en_b;
  assign shift_op  = ctrl_reg.shift_op;
  assign sel_A     = ctrl_reg.sel_a;
  assign sel_B     = ctrl_reg.sel_b;
  assign ALU_op    = ctrl_reg.alu_op;
  assign en_C      = ctrl_reg.en_c;
  assign en_status = ctrl_reg.en_status;
  assign wb_sel    = ctrl_reg.wb_sel;
  assign sximm8    = sximm8_reg;
  assign sximm5    = sximm5_reg;
  assign illegal   = illegal_reg;

endmodule

// File: tb/tb_cpu_controller.sv
// Self-checking bench for cpu_controller: directed instructions, reset and ignore cases,
// then random instructions compared against an instruction-level behaviour model.
module tb_cpu_controller;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] in_w;
  logic        load, s;
  logic        w, w_en, en_A, en_B, sel_A, sel_B, en_C, en_status, illegal;
  logic [2:0]  r_addr, w_addr;
  logic [1:0]  shift_op, ALU_op, wb_sel;
  logic [15:0] sximm8, sximm5;

  int errors = 0;
  int checks = 0;

  cpu_controller #(.DATA_W(16), .REG_AW(3)) dut (
    .clk(clk), .rst_n(rst_n), .in(in_w), .load(load), .s(s), .w(w),
    .r_addr(r_addr), .w_addr(w_addr), .w_en(w_en), .en_A(en_A), .en_B(en_B),
    .shift_op(shift_op), .sel_A(sel_A), .sel_B(sel_B), .ALU_op(ALU_op),
    .en_C(en_C), .en_status(en_status), .wb_sel(wb_sel),
    .sximm8(sximm8), .sximm5(sximm5), .illegal(illegal)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Issue one instruction (optionally loading it) and compare the observed
  // control activity against what the ISA says that instruction must do.
  task automatic run_instr(input logic [15:0] word, input string tag, input bit do_load);
    int e_lat = 2, e_a = -1, e_b = -1, e_wen = 0, e_waddr = 0, e_wbsel = 0;
    int e_st = 0, e_c = 0, e_alu = 0, e_sela = 0;
    int e_shift, e_imm8, e_imm5;
    int lat = 0, a_cnt = 0, a_addr = 0, b_cnt = 0, b_addr = 0, wen_cnt = 0, wen_addr = 0;
    int wen_sel = 0, st_cnt = 0, c_cnt = 0, c_alu = 0, c_shift = 0, c_sela = 0;
    int incons = 0, selb_cnt = 0, ill_cnt = 0;
    logic [15:0] imm8, imm5;
    int rn = int'(word[10:8]);
    int rd = int'(word[7:5]);
    int rm = int'(word[2:0]);
    e_shift = int'(word[4:3]);
    e_imm8  = word[7] ? int'(word[7:0]) + 32'hFF00 : int'(word[7:0]);
    e_imm5  = word[4] ? int'(word[4:0]) + 32'hFFE0 : int'(word[4:0]);
    case (word[15:11])
      5'b11010: begin e_lat = 3; e_wen = 1; e_waddr = rn; e_wbsel = 2; end
      5'b11000: begin e_lat = 5; e_b = rm; e_wen = 1; e_waddr = rd; e_c = 2; e_alu = 0; e_sela = 1; end
      5'b10100: begin e_lat = 6; e_a = rn; e_b = rm; e_wen = 1; e_waddr = rd; e_c = 2; e_alu = 0; end
      5'b10101: begin e_lat = 5; e_a = rn; e_b = rm; e_st = 1; e_c = 1; e_alu = 1; end
      5'b10110: begin e_lat = 6; e_a = rn; e_b = rm; e_wen = 1; e_waddr = rd; e_c = 2; e_alu = 2; end
      5'b10111: begin e_lat = 5; e_b = rm; e_wen = 1; e_waddr = rd; e_c = 2; e_alu = 3; end
      default:  e_lat = 2;
    endcase

    in_w = word; load = do_load; s = 1'b1;
    tick();
    load = 1'b0; s = 1'b0; in_w = 16'($urandom);
    imm8 = sximm8; imm5 = sximm5;
    for (int n = 1; n <= 30; n++) begin
      if (w === 1'b1) begin lat = n; break; end
      if (illegal !== 1'b0) ill_cnt++;
      if (sel_B !== 1'b0) selb_cnt++;
      if (en_A) begin a_cnt++; a_addr = int'(r_addr); end
      if (en_B) begin b_cnt++; b_addr = int'(r_addr); end
      if (w_en) begin wen_cnt++; wen_addr = int'(w_addr); wen_sel = int'(wb_sel); end
      if (en_status) begin st_cnt++; if (!en_C) incons++; end
      if (en_C) begin
        if (c_cnt == 0) begin
          c_alu = int'(ALU_op); c_shift = int'(shift_op); c_sela = int'(sel_A);
        end else if (c_alu != int'(ALU_op) || c_shift != int'(shift_op) || c_sela != int'(sel_A)) begin
          incons++;
        end
        c_cnt++;
      end
      tick();
    end

    $display("instr %s word=0x%04h latency=%0d wen=%0d waddr=%0d en_c=%0d", tag, word, lat, wen_cnt, wen_addr, c_cnt);
    check({tag, ".latency"}, 32'(lat), 32'(e_lat));
    check({tag, ".en_A_count"}, 32'(a_cnt), 32'(e_a >= 0 ? 1 : 0));
    if (e_a >= 0) check({tag, ".rn_read"}, 32'(a_addr), 32'(e_a));
    check({tag, ".en_B_count"}, 32'(b_cnt), 32'(e_b >= 0 ? 1 : 0));
    if (e_b >= 0) check({tag, ".rm_read"}, 32'(b_addr), 32'(e_b));
    check({tag, ".w_en_count"}, 32'(wen_cnt), 32'(e_wen));
    if (e_wen > 0) begin
      check({tag, ".w_addr"}, 32'(wen_addr), 32'(e_waddr));
      check({tag, ".wb_sel"}, 32'(wen_sel), 32'(e_wbsel));
    end
    check({tag, ".en_status_count"}, 32'(st_cnt), 32'(e_st));
    check({tag, ".en_C_count"}, 32'(c_cnt), 32'(e_c));
    if (e_c > 0) begin
      check({tag, ".ALU_op"}, 32'(c_alu), 32'(e_alu));
      check({tag, ".shift_op"}, 32'(c_shift), 32'(e_shift));
      check({tag, ".sel_A"}, 32'(c_sela), 32'(e_sela));
    end
    check({tag, ".held_controls"}, 32'(incons), 32'd0);
    check({tag, ".sel_B"}, 32'(selb_cnt), 32'd0);
    check({tag, ".illegal"}, 32'(ill_cnt), 32'd0);
    check({tag, ".sximm8"}, 32'(imm8), 32'(e_imm8));
    check({tag, ".sximm5"}, 32'(imm5), 32'(e_imm5));
    check({tag, ".idle_enables"}, 32'({w_en, en_A, en_B, en_C, en_status}), 32'd0);
    if (lat == 0) begin
      rst_n = 1'b0; tick(); rst_n = 1'b1; tick();
    end
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, ".w"}, 32'(w), 32'd1);
    check({tag, ".enables"}, 32'({w_en, en_A, en_B, en_C, en_status, sel_A, sel_B}), 32'd0);
    check({tag, ".fields"}, 32'({r_addr, w_addr, shift_op, ALU_op, wb_sel}), 32'd0);
    check({tag, ".sximm"}, {sximm8, sximm5}, 32'd0);
    check({tag, ".illegal"}, 32'(illegal), 32'd0);
  endtask

  initial begin
    logic [4:0] legal_keys [6];
    logic [4:0] key;
    logic [15:0] word;
    int cls, w_hi;
    legal_keys = '{5'b11010, 5'b11000, 5'b10100, 5'b10101, 5'b10110, 5'b10111};

    rst_n = 1'b0; load = 1'b0; s = 1'b0; in_w = 16'h0000;
    tick(); tick();
    check_reset_state("reset");
    rst_n = 1'b1;
    tick();

    run_instr(16'hD007, "mov_imm_r0", 1'b1);
    run_instr(16'hD1FE, "mov_imm_r1_neg", 1'b1);
    run_instr(16'hA148, "add_lsl1", 1'b1);
    run_instr(16'hA900, "cmp", 1'b1);
    run_instr(16'hB860, "mvn", 1'b1);
    run_instr(16'hC000, "mov_reg", 1'b1);

`ifdef CPU_CTRL_ILLEGAL_TRAP_EN
    in_w = 16'h0000; load = 1'b1; s = 1'b1;
    tick();
    load = 1'b0; s = 1'b0;
    w_hi = 0;
    for (int n = 0; n < 20; n++) begin
      tick();
      if (w !== 1'b0) w_hi++;
      s = 1'b1;
    end
    s = 1'b0;
    $display("instr undef_trap word=0x0000 w_high_cycles=%0d illegal=%0b", w_hi, illegal);
    check("trap.w_low", 32'(w_hi), 32'd0);
    check("trap.illegal", 32'(illegal), 32'd1);
    check("trap.enables", 32'({w_en, en_A, en_B, en_C, en_status}), 32'd0);
    rst_n = 1'b0; tick(); rst_n = 1'b1;
    check_reset_state("trap_reset");
    tick();
`else
    w_hi = 0;
    run_instr(16'h0000, "undef_nop", 1'b1);
`endif

    // Reset during GET_B of an ADD.
    in_w = 16'hA148; load = 1'b1; s = 1'b1;
    tick();
    load = 1'b0; s = 1'b0;
    tick(); tick();
    check("midrst.en_B", 32'(en_B), 32'd1);
    check("midrst.r_addr", 32'(r_addr), 32'd0);
    rst_n = 1'b0;
    tick();
    $display("instr midreset word=0xa148 w=%0b en_B=%0b sximm8=0x%04h", w, en_B, sximm8);
    check_reset_state("midrst");
    rst_n = 1'b1;
    tick();

    // load and s while in CALC of a CMP are ignored.
    in_w = 16'hA900; load = 1'b1; s = 1'b1;
    tick();
    load = 1'b0; s = 1'b0;
    tick(); tick(); tick();
    check("ignore.in_calc", 32'(en_status), 32'd1);
    in_w = 16'hD0FF; load = 1'b1; s = 1'b1;
    tick();
    load = 1'b0; s = 1'b0;
    $display("instr load_in_calc w=%0b sximm8=0x%04h", w, sximm8);
    check("ignore.w_back", 32'(w), 32'd1);
    check("ignore.ir_kept", 32'(sximm8), 32'h0000);
    run_instr(16'hA900, "cmp_rerun", 1'b0);

    for (int i = 0; i < 40; i++) begin
`ifdef CPU_CTRL_ILLEGAL_TRAP_EN
      cls = int'($urandom_range(0, 5));
`else
      cls = int'($urandom_range(0, 6));
`endif
      if (cls < 6) begin
        key = legal_keys[cls];
      end else begin
        key = 5'($urandom_range(0, 31));
        while (key == 5'b11010 || key == 5'b11000 || key[4:2] == 3'b101)
          key = 5'($urandom_range(0, 31));
      end
      word = {key, 11'($urandom)};
      run_instr(word, $sformatf("rand%0d", i), 1'b1);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
